// File: rtl/alu_pkg.sv
// Shared constants and result type for the 4-bit 74181-style ALU.
// Latency: n/a (package).
// Backpressure: n/a (package).
package alu_pkg;

  // Mode select values for the m input
  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;

  // Common function selects (SUB and XOR share a code; m picks which one)
  localparam logic [3:0] SEL_ADD   = 4'b1001;
  localparam logic [3:0] SEL_SUB   = 4'b0110;
  localparam logic [3:0] SEL_PASSA = 4'b1111;
  localparam logic [3:0] SEL_XOR   = 4'b0110;

  // Everything the ALU drives out, bundled so it can be registered as one word
  typedef struct packed {
    logic       cout;
    logic [3:0] f;
    logic       p;
    logic       g;
  } alu_res_t;

  // Replicate one select bit across the 4-bit datapath
  function automatic logic [3:0] rep4(input logic bit_in);
    return {4{bit_in}};
  endfunction

endpackage

// File: rtl/alu_4bit_core.sv
// Combinational 74181 function core: X/Y terms, result, carry-out, group P/G.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows the inputs continuously.
module alu_4bit_core
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       m,
  input  logic [3:0] s,
  output alu_res_t   res
);

  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] sum;
  logic       grp_p;
  logic       grp_g;

  // Build the per-bit X/Y terms, then derive the result and lookahead outputs.
  // Y is always a bitwise subset of X, so carry-out from the G/P lookahead
  // equals bit 4 of X+Y+cin; using the lookahead form gives the same cout in
  // logic mode as well, which cascaded units rely on.
  always_comb begin
    x     = a | (b & rep4(s[0])) | (~b & rep4(s[1]));
    y     = (a & ~b & rep4(s[2])) | (a & b & rep4(s[3]));
    sum   = x + y + {3'b000, cin};
    grp_p = &x;
    grp_g = y[3]
          | (x[3] & y[2])
          | (x[3] & x[2] & y[1])
          | (x[3] & x[2] & x[1] & y[0]);

    res      = '0;
    res.p    = grp_p;
    res.g    = grp_g;
    res.cout = grp_g | (grp_p & cin);
    res.f    = (m == MODE_LOGIC) ? ~(x ^ y) : sum;
  end

endmodule

// File: rtl/alu_4bit.sv
// 4-bit 74181-style ALU with registered f/cout/p/g (optional a_eq_b via ALU_AEQB_EN).
// Latency: one cycle; inputs before edge N appear on outputs after edge N.
// Backpressure: none; outputs are re-captured every clock, no enable or handshake.
module alu_4bit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       m,
  input  logic [3:0] s,
  output logic       cout,
  output logic [3:0] f,
  output logic       p,
`ifdef ALU_AEQB_EN
  output logic       a_eq_b,
`endif
  output logic       g
);

  alu_res_t core_res;
  alu_res_t res_d;
  alu_res_t res_q;

  alu_4bit_core u_core (
    .a   (a),
    .b   (b),
    .cin (cin),
    .m   (m),
    .s   (s),
    .res (core_res)
  );

`ifdef ALU_AEQB_EN
  logic a_eq_b_d;
  logic a_eq_b_q;

  // All-ones result flags A==B when running A-B-1 with no carry-in
  always_comb begin
    a_eq_b_d = (core_res.f == 4'hF);
  end

  // Equality flag shares the output register stage and its reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_eq_b_q <= 1'b0;
    end else begin
      a_eq_b_q <= a_eq_b_d;
    end
  end

  assign a_eq_b = a_eq_b_q;
`endif

  // Next-state for the output register is the core result as-is
  always_comb begin
    res_d = core_res;
  end

  // Output register stage; reset clears every output without waiting for clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign cout = res_q.cout;
  assign f    = res_q.f;
  assign p    = res_q.p;
  assign g    = res_q.g;

endmodule

// File: tb/tb_alu_4bit.sv
// Bench for alu_4bit: directed vectors, expected results queued by the driver
// and checked by an independent monitor one clock after capture.
// Define ALU_AEQB_EN to also check the a_eq_b output.
module tb_alu_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       m;
  logic [3:0] s;
  logic       cout;
  logic [3:0] f;
  logic       p;
  logic       g;
`ifdef ALU_AEQB_EN
  logic       a_eq_b;
`endif

  int errors;
  int checks;

  typedef struct {
    string      name;
    logic [6:0] res;   // {cout, f, p, g}
    logic       aeq;
  } exp_t;

  exp_t exp_q[$];

  alu_4bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .m      (m),
    .s      (s),
    .cout   (cout),
    .f      (f),
    .p      (p),
`ifdef ALU_AEQB_EN
    .a_eq_b (a_eq_b),
`endif
    .g      (g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one vector at the falling edge and queue its hand-computed result
  task automatic drive(input string name, input logic [3:0] ta, input logic [3:0] tb,
                       input logic tcin, input logic tm, input logic [3:0] ts,
                       input logic [3:0] ef, input logic ec, input logic ep,
                       input logic eg, input logic eaeq);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; m = tm; s = ts;
    e.name = name;
    e.res  = {ec, ef, ep, eg};
    e.aeq  = eaeq;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    logic [6:0] act;
    act = {cout, f, p, g};
    checks++;
    if (act !== 7'd0) begin
      errors++;
      $display("FAIL %s: {cout,f,p,g} got %b want 0000000", name, act);
    end
`ifdef ALU_AEQB_EN
    checks++;
    if (a_eq_b !== 1'b0) begin
      errors++;
      $display("FAIL %s a_eq_b: got %b want 0", name, a_eq_b);
    end
`endif
  endtask

  // Monitor: one clock after each queued vector, compare registered outputs
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {cout, f, p, g};
        checks++;
        if (act !== e.res) begin
          errors++;
          $display("FAIL %s: {cout,f,p,g} got %b_%b_%b_%b want %b_%b_%b_%b", e.name,
                   act[6], act[5:2], act[1], act[0],
                   e.res[6], e.res[5:2], e.res[1], e.res[0]);
        end
`ifdef ALU_AEQB_EN
        checks++;
        if (a_eq_b !== e.aeq) begin
          errors++;
          $display("FAIL %s a_eq_b: got %b want %b", e.name, a_eq_b, e.aeq);
        end
`endif
      end
    end
  end

  initial begin
    exp_t e;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    a = 4'h0; b = 4'h0; cin = 1'b0; m = 1'b0; s = 4'h0;

    #3;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    //     name           a        b        cin  m    s        f        cout p    g    aeq
    drive("add",          4'b0010, 4'b0001, 1'b0, 1'b0, 4'b1001, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("sub_m1",       4'b0010, 4'b0001, 1'b0, 1'b0, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    drive("or_plus_c",    4'b0010, 4'b0101, 1'b1, 1'b0, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("minus1_c0",    4'b0101, 4'b1010, 1'b0, 1'b0, 4'b0011, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
    drive("minus1_c1",    4'b0101, 4'b1010, 1'b1, 1'b0, 4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    drive("log_nota",     4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("log_nand",     4'b0010, 4'b0101, 1'b0, 1'b1, 4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
    drive("sub_c1",       4'b0111, 4'b0011, 1'b1, 1'b0, 4'b0110, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0);
    drive("a_eq_b",       4'b0101, 4'b0101, 1'b0, 1'b0, 4'b0110, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
    drive("add_wrap",     4'b1111, 4'b0001, 1'b0, 1'b0, 4'b1001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    drive("log_xor",      4'b1100, 4'b1010, 1'b0, 1'b1, 4'b0110, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0);
    drive("log_passa",    4'b1001, 4'b0110, 1'b1, 1'b1, 4'b1111, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b0);
    drive("a_minus1",     4'b0000, 4'b0011, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
    drive("log_and",      4'b1100, 4'b1010, 1'b1, 1'b1, 4'b1011, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset between edges: outputs must clear at once and stay clear
    drive("pre_rst_add",  4'b0010, 4'b0001, 1'b0, 1'b0, 4'b1001, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #2;
    check_zero("rst_hold_edge");
    @(negedge clk);
    rst_n = 1'b1;
    e.name = "post_rst_add";
    e.res  = {1'b0, 4'b0011, 1'b0, 1'b0};
    e.aeq  = 1'b0;
    exp_q.push_back(e);
    #1;
    check_zero("rst_release_pre_edge");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results never checked, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
